// File: rtl/phone_ring_controller.sv
`timescale 1ns/1ps
// phone_ring_controller
//   Drives the ringer for an incoming call. The ringer pulses in bursts of
//   RING_ON_CYCLES on and RING_OFF_CYCLES off. It stops when the user answers
//   or rejects the call, or when the caller hangs up. After MAX_RINGS bursts
//   with no answer, the call is declared missed.
//
// Ports
//   clock         in   single clock, all logic on the rising edge
//   reset         in   synchronous, active-high reset
//   incoming_call in   level, high while a caller is present
//   answer        in   user answer request, sampled every cycle
//   hangup        in   user hangup/reject request, sampled every cycle
//   is_ringing    out  ringer drive, high only in RING_ON
//   in_call       out  high while a call is connected
//   missed_call   out  one-cycle pulse per missed call
//   missed_count  out  count of missed calls, saturating at 15
module phone_ring_controller #(
  parameter int RING_ON_CYCLES  = 8,
  parameter int RING_OFF_CYCLES = 4,
  parameter int MAX_RINGS       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       incoming_call,
  input  logic       answer,
  input  logic       hangup,
  output logic       is_ringing,
  output logic       in_call,
  output logic       missed_call,
  output logic [3:0] missed_count
);

  localparam int TIMER_MAX = (RING_ON_CYCLES > RING_OFF_CYCLES) ? RING_ON_CYCLES
                                                                 : RING_OFF_CYCLES;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int BW = $clog2(MAX_RINGS + 1);

  localparam logic [TW-1:0] ON_LAST    = TW'(RING_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(RING_OFF_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_RINGS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RING_ON  = 3'd1,
    RING_OFF = 3'd2,
    IN_CALL  = 3'd3,
    MISSED   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [BW-1:0] burst;
  logic          incoming_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments, so every register
  // below is updated from the values it held before this clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      burst        <= '0;
      incoming_d   <= 1'b0;
      missed_count <= 4'd0;
    end else begin
      incoming_d <= incoming_call;
      case (state)
        IDLE: begin
          // Ringing starts only on a rising edge of the caller level. A caller
          // still held high after a call ends cannot restart the ringer.
          if (incoming_call && !incoming_d) begin
            state <= RING_ON;
            timer <= '0;
            burst <= '0;
          end
        end

        RING_ON, RING_OFF: begin
          if (answer) begin
            state <= IN_CALL;
          end else if (hangup) begin
            state <= IDLE;                  // rejected, not counted as missed
          end else if (!incoming_call) begin
            state        <= MISSED;
            missed_count <= sat_inc(missed_count);
          end else if (state == RING_ON) begin
            if (timer == ON_LAST) begin
              state <= RING_OFF;
              timer <= '0;
              burst <= burst + BW'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              if (burst == BURST_LAST) begin
                state        <= MISSED;
                missed_count <= sat_inc(missed_count);
              end else begin
                state <= RING_ON;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end

        IN_CALL: begin
          if (hangup || !incoming_call) state <= IDLE;
        end

        MISSED: state <= IDLE;

        default: state <= IDLE;             // illegal encodings recover here
      endcase
    end
  end

  // NOTE: outputs are continuous decodes of the state register, so no latch
  // can be inferred, and an illegal encoding decodes to all outputs low.
  assign is_ringing  = (state == RING_ON);
  assign in_call     = (state == IN_CALL);
  assign missed_call = (state == MISSED);

endmodule
